// File: rtl/ail_rmw_pkg.sv
// rtl/ail_rmw_pkg.sv - auto-index codes and FSM state encodings shared with the decoder
package ail_rmw_pkg;

  typedef enum logic [1:0] {
    AIDX_NONE = 2'b00,
    AIDX_INC  = 2'b01,
    AIDX_DEC  = 2'b10,
    AIDX_RSVD = 2'b11
  } aidx_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_MOD  = 3'd2,
    ST_WR   = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  // Wait counter width; large enough for any WAIT_MAX up to 255
  localparam int WCNT_W = 8;

  // The reserved code behaves as "no auto-index"
  function automatic aidx_t norm_idx(input logic [1:0] code);
    return (code == AIDX_RSVD) ? AIDX_NONE : aidx_t'(code);
  endfunction

endpackage

// File: rtl/ail_rmw_if.sv
// rtl/ail_rmw_if.sv - memory bus between the RMW sequencer and the memory port
interface ail_rmw_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_rd;
  logic          mem_wr;
  logic          mem_ack;

  modport master (
    output mem_addr, mem_wdata, mem_rd, mem_wr,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_rd, mem_wr,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/ail_rmw_incdec.sv
// rtl/ail_rmw_incdec.sv - combinational pointer +1/-1 unit with effective-address select
module ail_rmw_incdec
  import ail_rmw_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [DW-1:0] p,
  input  aidx_t         mode,
  output logic [DW-1:0] n,
  output logic [DW-1:0] ea_nxt
);

  localparam logic [DW-1:0] ONE = DW'(1);

  // Post-increment exposes the old pointer, pre-decrement the new one; both wrap mod 2^DW
  always_comb begin
    n      = p;
    ea_nxt = p;
    if (mode == AIDX_INC) begin
      n      = p + ONE;
      ea_nxt = p;
    end else if (mode == AIDX_DEC) begin
      n      = p - ONE;
      ea_nxt = p - ONE;
    end
  end

endmodule

// File: rtl/ail_rmw.sv
// rtl/ail_rmw.sv - auto-index read-modify-write sequencer between decode and the memory bus
module ail_rmw
  import ail_rmw_pkg::*;
#(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          start,
  input  logic [1:0]    idx,
  input  logic [AW-1:0] ptr_addr,
  ail_rmw_if.master     bus,
  output logic [DW-1:0] ea,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAIT_MAX - 1);
  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);

  state_t            state, state_nxt;
  aidx_t             idx_q;
  logic [AW-1:0]     addr_q;
  logic [DW-1:0]     p_q;
  logic [DW-1:0]     wdata_q;
  logic [DW-1:0]     ea_q;
  logic [DW-1:0]     n_val;
  logic [DW-1:0]     ea_mod;
  logic [WCNT_W-1:0] wcnt;
  logic              err_q;
  logic              abort;
  logic              rd_o;
  logic              wr_o;
  logic              done_o;

  ail_rmw_incdec #(.DW(DW)) u_incdec (
    .p      (p_q),
    .mode   (idx_q),
    .n      (n_val),
    .ea_nxt (ea_mod)
  );

  // State register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next state and bus strobes; abort fires on the last permitted wait cycle
  always_comb begin
    state_nxt = state;
    rd_o      = 1'b0;
    wr_o      = 1'b0;
    done_o    = 1'b0;
    abort     = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RD;
      ST_RD: begin
        rd_o = 1'b1;
        if (bus.mem_ack) begin
          state_nxt = (idx_q == AIDX_NONE) ? ST_FIN : ST_MOD;
        end else if (wcnt == WCNT_LAST) begin
          abort     = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_MOD: state_nxt = ST_WR;
      ST_WR: begin
        wr_o = 1'b1;
        if (bus.mem_ack) begin
          state_nxt = ST_FIN;
        end else if (wcnt == WCNT_LAST) begin
          abort     = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_FIN: begin
        done_o    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Wait counter: runs only while a request is outstanding without ack, zero otherwise
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wcnt <= '0;
    end else if ((state == ST_RD || state == ST_WR) && !bus.mem_ack) begin
      wcnt <= wcnt + WCNT_ONE;
    end else begin
      wcnt <= '0;
    end
  end

  // Address, pointer, write-data and ea registers, plus the one-cycle error flag
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      idx_q   <= AIDX_NONE;
      addr_q  <= '0;
      p_q     <= '0;
      wdata_q <= '0;
      ea_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= abort;
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr_q <= ptr_addr;
            idx_q  <= norm_idx(idx);
          end
        end
        ST_RD: begin
          if (bus.mem_ack) begin
            p_q <= bus.mem_rdata;
            if (idx_q == AIDX_NONE) ea_q <= bus.mem_rdata;
          end
        end
        ST_MOD: begin
          wdata_q <= n_val;
          ea_q    <= ea_mod;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_rd    = rd_o;
  assign bus.mem_wr    = wr_o;
  assign ea            = ea_q;
  assign busy          = (state != ST_IDLE);
  assign done          = done_o;
  assign err           = err_q;

endmodule
